// File: rtl/tone_meter_pkg.sv
// Shared types and elaboration-time helpers for the tone meter: crossing states,
// hysteresis thresholds and derived register widths.
package tone_meter_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOW    = 2'd1,
        HIGH   = 2'd2
    } xing_state_t;

    function automatic int mid_level(input int data_width);
        return 1 << (data_width - 1);
    endfunction

    // Upper threshold; clamped to full scale so it always fits in data_width+1 bits.
    function automatic int hi_level(input int data_width, input int hysteresis);
        int hi;
        hi = mid_level(data_width) + hysteresis;
        if (hi > (1 << data_width)) hi = 1 << data_width;
        return hi;
    endfunction

    // Lower threshold; clamped at zero so a huge band simply never reports "below".
    function automatic int lo_level(input int data_width, input int hysteresis);
        int lo;
        lo = mid_level(data_width) - hysteresis;
        if (lo < 0) lo = 0;
        return lo;
    endfunction

    function automatic int acc_width(input int period_width, input int avg_log2);
        return period_width + avg_log2;
    endfunction

    function automatic int pcnt_width(input int avg_log2);
        return avg_log2 + 1;
    endfunction

endpackage

// File: rtl/tone_meter_if.sv
// Sample stream in, measurement results out, for the tone meter.
interface tone_meter_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int PERIOD_WIDTH = 16
);
    // Handshake: sample_valid qualifies sample and the meter consumes every
    // qualified sample (there is no ready); valid is a one-cycle strobe marking a
    // fresh result, and period/peak/trough/peak_to_peak hold until the next strobe.
    logic [DATA_WIDTH-1:0]   sample;
    logic                    sample_valid;
    logic [PERIOD_WIDTH-1:0] period;
    logic [DATA_WIDTH-1:0]   peak;
    logic [DATA_WIDTH-1:0]   trough;
    logic [DATA_WIDTH-1:0]   peak_to_peak;
    logic                    valid;
    logic                    timeout;

    modport master (
        output sample, sample_valid,
        input  period, peak, trough, peak_to_peak, valid, timeout
    );

    modport slave (
        input  sample, sample_valid,
        output period, peak, trough, peak_to_peak, valid, timeout
    );

endinterface

// File: rtl/tone_meter_crossing_detector.sv
// Hysteresis crossing FSM: reports a rising event when the signal moves from
// below the low threshold to at/above the high threshold.
module tone_meter_crossing_detector
    import tone_meter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int HYSTERESIS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic                  sample_valid,
    input  logic                  force_search,
    output logic                  rise,
    output xing_state_t           state
);

    // Thresholds carry one extra bit so HI can reach full scale without wrapping.
    localparam logic [DATA_WIDTH:0] HI_T = (DATA_WIDTH + 1)'(hi_level(DATA_WIDTH, HYSTERESIS));
    localparam logic [DATA_WIDTH:0] LO_T = (DATA_WIDTH + 1)'(lo_level(DATA_WIDTH, HYSTERESIS));

    logic        above;
    logic        below;
    xing_state_t state_next;

    assign above = {1'b0, sample} >= HI_T;
    assign below = {1'b0, sample} <  LO_T;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEARCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        rise       = 1'b0;
        if (sample_valid) begin
            case (state)
                SEARCH: begin
                    if (below)      state_next = LOW;
                    else if (above) state_next = HIGH;
                end
                LOW: begin
                    if (above) begin
                        state_next = HIGH;
                        rise       = 1'b1;
                    end
                end
                HIGH: begin
                    if (below) state_next = LOW;
                end
                default: state_next = SEARCH;
            endcase
            // Never asserted together with rise: a crossing beats a timeout.
            if (force_search) state_next = SEARCH;
        end
    end

endmodule

// File: rtl/tone_meter.sv
// Tone meter: averages the period between rising midscale crossings over
// 2^AVG_LOG2 periods and reports peak/trough of the same window.
module tone_meter
    import tone_meter_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int PERIOD_WIDTH = 16,
    parameter int HYSTERESIS   = 8,
    parameter int AVG_LOG2     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    tone_meter_if.slave bus,
    output xing_state_t dbg_state
);

    localparam int ACC_WIDTH  = acc_width(PERIOD_WIDTH, AVG_LOG2);
    localparam int PCNT_WIDTH = pcnt_width(AVG_LOG2);
    localparam logic [PERIOD_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [PCNT_WIDTH-1:0]   PCNT_LAST = PCNT_WIDTH'((1 << AVG_LOG2) - 1);

    logic                    rise;
    logic                    synced;
    logic                    expired;
    logic [PERIOD_WIDTH-1:0] cnt;
    logic [ACC_WIDTH-1:0]    acc;
    logic [ACC_WIDTH-1:0]    acc_sum;
    logic [PCNT_WIDTH-1:0]   pcnt;
    logic [DATA_WIDTH-1:0]   peak_trk;
    logic [DATA_WIDTH-1:0]   trough_trk;

    logic [PERIOD_WIDTH-1:0] period_r;
    logic [DATA_WIDTH-1:0]   peak_r;
    logic [DATA_WIDTH-1:0]   trough_r;
    logic [DATA_WIDTH-1:0]   p2p_r;
    logic                    valid_r;
    logic                    timeout_r;

    logic sync_start;
    logic synced_rise;
    logic window_end;
    logic time_out;

    tone_meter_crossing_detector #(
        .DATA_WIDTH (DATA_WIDTH),
        .HYSTERESIS (HYSTERESIS)
    ) u_detector (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample       (bus.sample),
        .sample_valid (bus.sample_valid),
        .force_search (time_out),
        .rise         (rise),
        .state        (dbg_state)
    );

    // rise is already qualified by sample_valid inside the detector.
    assign sync_start  = rise && !synced;
    assign synced_rise = rise && synced;
    assign window_end  = synced_rise && (pcnt == PCNT_LAST);
    // expired makes a saturated counter time out once, so the FSM can leave SEARCH again.
    assign time_out    = bus.sample_valid && !rise && (cnt == CNT_MAX) && !expired;
    assign acc_sum     = acc + ACC_WIDTH'(cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            acc        <= '0;
            pcnt       <= '0;
            synced     <= 1'b0;
            expired    <= 1'b0;
            peak_trk   <= '0;
            trough_trk <= '0;
            period_r   <= '0;
            peak_r     <= '0;
            trough_r   <= '0;
            p2p_r      <= '0;
            valid_r    <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            valid_r <= window_end;
            if (bus.sample_valid) begin
                if (rise) begin
                    cnt     <= PERIOD_WIDTH'(1);
                    expired <= 1'b0;
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end

                if (time_out) begin
                    synced    <= 1'b0;
                    expired   <= 1'b1;
                    acc       <= '0;
                    pcnt      <= '0;
                    timeout_r <= 1'b1;
                end else if (sync_start) begin
                    synced     <= 1'b1;
                    acc        <= '0;
                    pcnt       <= '0;
                    peak_trk   <= bus.sample;
                    trough_trk <= bus.sample;
                end else if (window_end) begin
                    // Results exclude the closing crossing sample, which seeds the next window.
                    period_r   <= PERIOD_WIDTH'(acc_sum >> AVG_LOG2);
                    peak_r     <= peak_trk;
                    trough_r   <= trough_trk;
                    p2p_r      <= peak_trk - trough_trk;
                    timeout_r  <= 1'b0;
                    acc        <= '0;
                    pcnt       <= '0;
                    peak_trk   <= bus.sample;
                    trough_trk <= bus.sample;
                end else if (synced) begin
                    if (rise) begin
                        acc  <= acc_sum;
                        pcnt <= pcnt + 1'b1;
                    end
                    if (bus.sample > peak_trk)   peak_trk   <= bus.sample;
                    if (bus.sample < trough_trk) trough_trk <= bus.sample;
                end
            end
        end
    end

    assign bus.period       = period_r;
    assign bus.peak         = peak_r;
    assign bus.trough       = trough_r;
    assign bus.peak_to_peak = p2p_r;
    assign bus.valid        = valid_r;
    assign bus.timeout      = timeout_r;

endmodule
